// File: rtl/uart_port_in.sv
// uart_port_in: 8N1 UART receiver that buffers complete bytes in a small FIFO
// and presents the head byte on the processor's PortIn bus.
module uart_port_in #(
  parameter int BAUD_DIV   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       pop,
  input  logic       clear_errors,
  output logic [7:0] PortIn,
  output logic       data_valid,
  output logic       fifo_full,
  output logic       overrun,
  output logic       frame_error
);

  localparam int TMR_W = $clog2(BAUD_DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Timer is a down-counter; a bit period expires when it reaches zero.
  localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(BAUD_DIV / 2 - 1);
  localparam logic [TMR_W-1:0] FULL_LOAD = TMR_W'(BAUD_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_ZERO  = TMR_W'(0);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic             sync1_r;
  logic             rxs_r;
  state_t           state_r, state_s;
  logic [TMR_W-1:0] timer_r, timer_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic [7:0]       shift_r, shift_s;
  logic             push_s;
  logic             frame_err_s;
  logic             frame_error_r;

  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             overrun_r;
  logic             do_push_s, do_pop_s, overrun_set_s;
  logic [7:0]       port_in_s;

  // Two-flop synchronizer for the asynchronous rx pin; idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
    end else begin
      sync1_r <= rx;
      rxs_r   <= sync1_r;
    end
  end

  // Receiver state, bit timer, bit index, shift register and error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      timer_r       <= TMR_ZERO;
      bit_idx_r     <= 3'd0;
      shift_r       <= 8'h00;
      frame_error_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      timer_r       <= timer_s;
      bit_idx_r     <= bit_idx_s;
      shift_r       <= shift_s;
      frame_error_r <= frame_err_s;
    end
  end

  // Frame decoder: mid-bit sampling of start, eight data bits (LSB first) and stop.
  always_comb begin
    state_s     = state_r;
    timer_s     = timer_r;
    bit_idx_s   = bit_idx_r;
    shift_s     = shift_r;
    push_s      = 1'b0;
    frame_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rxs_r) begin
          state_s = ST_START;
          timer_s = HALF_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (timer_r == TMR_ZERO) begin
          if (rxs_r) begin
            // Line went back high before mid start bit: treat as a glitch.
            state_s = ST_IDLE;
          end else begin
            state_s   = ST_DATA;
            timer_s   = FULL_LOAD;
            bit_idx_s = 3'd0;
          end
        end else begin
          timer_s = timer_r - TMR_ONE;
        end
      end
      ST_DATA: begin
        if (timer_r == TMR_ZERO) begin
          shift_s = {rxs_r, shift_r[7:1]};
          timer_s = FULL_LOAD;
          if (bit_idx_r == 3'd7) begin
            state_s = ST_STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          timer_s = timer_r - TMR_ONE;
        end
      end
      ST_STOP: begin
        if (timer_r == TMR_ZERO) begin
          state_s = ST_IDLE;
          if (rxs_r) begin
            push_s = 1'b1;
          end else begin
            frame_err_s = 1'b1;
          end
        end else begin
          timer_s = timer_r - TMR_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // A pop on an empty FIFO is ignored; a push when full needs a same-cycle pop.
  assign do_pop_s      = pop && (count_r != CNT_ZERO);
  assign do_push_s     = push_s && ((count_r != CNT_FULL) || do_pop_s);
  assign overrun_set_s = push_s && (count_r == CNT_FULL) && !pop;

  // FIFO storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_ZERO;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overrun flag; a new overrun takes priority over clear_errors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_r <= 1'b0;
    end else if (overrun_set_s) begin
      overrun_r <= 1'b1;
    end else if (clear_errors) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  // Head byte onto the bus, forced to zero while the FIFO is empty.
  always_comb begin
    port_in_s = 8'h00;
    if (count_r != CNT_ZERO) begin
      port_in_s = mem_r[rd_ptr_r];
    end else begin
      port_in_s = 8'h00;
    end
  end

  assign PortIn      = port_in_s;
  assign data_valid  = (count_r != CNT_ZERO);
  assign fifo_full   = (count_r == CNT_FULL);
  assign overrun     = overrun_r;
  assign frame_error = frame_error_r;

endmodule

// File: tb/tb_uart_port_in.sv
// tb_uart_port_in: scoreboard bench for uart_port_in. A queue-based FIFO model
// predicts which bytes come out; a monitor pops and compares them.
module tb_uart_port_in;

  localparam int BD    = 16;
  localparam int DEPTH = 4;
  localparam int LAT   = 3 + BD / 2 + 9 * BD;   // pin fall to data_valid

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       pop;
  logic       clear_errors;
  logic [7:0] PortIn;
  logic       data_valid;
  logic       fifo_full;
  logic       overrun;
  logic       frame_error;

  logic       pop_drv;
  logic       pop_mon;
  logic       mon_en;
  logic       exp_ovr;
  logic       fe_prev;
  logic [7:0] exp_q[$];
  int         cyc      = 0;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         fe_seen  = 0;
  int         fe_exp   = 0;

  assign pop = pop_drv | pop_mon;

  uart_port_in #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .pop         (pop),
    .clear_errors(clear_errors),
    .PortIn      (PortIn),
    .data_valid  (data_valid),
    .fifo_full   (fifo_full),
    .overrun     (overrun),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_portin"},  32'(PortIn),      32'h0);
    chk({tag, "_valid"},   32'(data_valid),  32'h0);
    chk({tag, "_full"},    32'(fifo_full),   32'h0);
    chk({tag, "_overrun"}, 32'(overrun),     32'h0);
    chk({tag, "_fe"},      32'(frame_error), 32'h0);
  endtask

  // Reference model: what the receiver should do with one frame.
  task automatic expect_frame(input logic [7:0] b, input logic stop_bit);
    if (!stop_bit) fe_exp++;
    else if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  // Drives one 8N1 frame on rx, BD cycles per bit, starting at the next negedge.
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk); rx = 1'b0;
    repeat (BD - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); rx = b[i];
      repeat (BD - 1) @(negedge clk);
    end
    @(negedge clk); rx = stop_bit;
    repeat (BD - 1) @(negedge clk);
    if (!stop_bit) begin
      @(negedge clk); rx = 1'b1;
      repeat (BD - 1) @(negedge clk);
    end
  endtask

  // Checks outputs around the exact cycle the frame result should appear.
  task automatic check_edge(input string tag, input logic exp_dv, input logic [7:0] exp_byte,
                            input logic exp_fe);
    @(negedge clk);
    repeat (LAT - 1) @(negedge clk);
    chk({tag, "_dv_early"}, 32'(data_valid), 32'h0);
    chk({tag, "_fe_early"}, 32'(frame_error), 32'h0);
    @(negedge clk);
    chk({tag, "_dv"},     32'(data_valid),  32'(exp_dv));
    chk({tag, "_portin"}, 32'(PortIn),      32'(exp_byte));
    chk({tag, "_fe"},     32'(frame_error), 32'(exp_fe));
    @(negedge clk);
    chk({tag, "_fe_end"}, 32'(frame_error), 32'h0);
  endtask

  // Processor-side pop with checks of the head before and after.
  task automatic do_pop(input string tag);
    logic       had;
    logic [7:0] head;
    @(negedge clk);
    had  = (exp_q.size() != 0);
    head = had ? exp_q.pop_front() : 8'h00;
    chk({tag, "_head"}, 32'(PortIn), 32'(head));
    chk({tag, "_dv"},   32'(data_valid), 32'(had));
    pop_drv = 1'b1;
    @(negedge clk);
    pop_drv = 1'b0;
    chk({tag, "_next"}, 32'(PortIn), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
    chk({tag, "_full"}, 32'(fifo_full), 32'(exp_q.size() == DEPTH));
  endtask

  // Sends a good frame with pop asserted in the very cycle the byte is pushed.
  task automatic frame_pop_at_push(input string tag, input logic [7:0] b);
    logic       had;
    logic [7:0] head;
    had  = (exp_q.size() != 0);
    head = had ? exp_q.pop_front() : 8'h00;
    expect_frame(b, 1'b1);
    fork
      drive_frame(b, 1'b1);
      begin
        @(negedge clk);
        repeat (LAT - 1) @(negedge clk);
        chk({tag, "_head"}, 32'(PortIn), 32'(head));
        pop_drv = 1'b1;
        @(negedge clk);
        pop_drv = 1'b0;
        chk({tag, "_after"}, 32'(PortIn), 32'(exp_q[0]));
        chk({tag, "_full"},  32'(fifo_full), 32'(exp_q.size() == DEPTH));
        chk({tag, "_ovr"},   32'(overrun), 32'(exp_ovr));
      end
    join
  endtask

  // Bounded wait for the monitor to consume every predicted byte.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || data_valid) && n < 4 * BD) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_left"}, 32'(exp_q.size()), 32'h0);
    chk({tag, "_dv"},   32'(data_valid), 32'h0);
  endtask

  // Monitor: whenever a byte is presented, compare it with the scoreboard and pop it.
  initial begin
    pop_mon = 1'b0;
    forever begin
      @(negedge clk);
      pop_mon = 1'b0;
      if (mon_en && reset && data_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL mon_unexpected: got byte 0x%0h, expected none", PortIn);
        end else begin
          chk("mon_byte", 32'(PortIn), 32'(exp_q.pop_front()));
        end
        pop_mon = 1'b1;
      end
    end
  end

  // Frame-error pulse counter; pulses must be exactly one cycle wide.
  initial begin
    fe_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_error) begin
        fe_seen++;
        if (fe_prev) begin
          n_checks++;
          n_fail++;
          $display("FAIL fe_width: got pulse longer than 1 cycle, expected 1 cycle");
        end
      end
      fe_prev = frame_error;
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got no end of test, expected finish within 90000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rb;
    logic       rs;
    int         gap;

    reset = 1'b0; rx = 1'b1; pop_drv = 1'b0; clear_errors = 1'b0;
    mon_en = 1'b0; exp_ovr = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk_reset_vals("idle");

    // Single byte with exact latency, then pop and pop-on-empty.
    expect_frame(8'hA5, 1'b1);
    fork
      drive_frame(8'hA5, 1'b1);
      check_edge("single", 1'b1, 8'hA5, 1'b0);
    join
    do_pop("single_pop");
    do_pop("empty_pop");

    // Start-bit glitch: four low cycles then high.
    @(negedge clk); rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BD) @(negedge clk);
    chk("glitch_dv", 32'(data_valid), 32'h0);
    chk("glitch_fe", 32'(fe_seen), 32'(fe_exp));
    frame_pop_at_push("empty_pushpop", 8'h3C);
    do_pop("glitch_pop");

    // Framing error, then a good frame.
    expect_frame(8'h55, 1'b0);
    fork
      drive_frame(8'h55, 1'b0);
      check_edge("frame_err", 1'b0, 8'h00, 1'b1);
    join
    chk("frame_err_dv", 32'(data_valid), 32'h0);
    mon_en = 1'b1;
    expect_frame(8'h81, 1'b1);
    drive_frame(8'h81, 1'b1);
    drain("after_fe");
    mon_en = 1'b0;

    // Overrun: five back-to-back frames into a depth-4 FIFO.
    for (int b = 1; b <= 5; b++) begin
      expect_frame(8'(b), 1'b1);
      drive_frame(8'(b), 1'b1);
    end
    chk("ovr_full", 32'(fifo_full), 32'(exp_q.size() == DEPTH));
    chk("ovr_flag", 32'(overrun), 32'(exp_ovr));
    // clear_errors in the same cycle as another dropped byte: overrun stays set.
    expect_frame(8'h06, 1'b1);
    fork
      drive_frame(8'h06, 1'b1);
      begin
        @(negedge clk);
        repeat (LAT - 1) @(negedge clk);
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
        chk("clr_vs_ovr", 32'(overrun), 32'(exp_ovr));
      end
    join
    for (int i = 0; i < 5; i++) do_pop("ovr_pop");
    chk("ovr_sticky", 32'(overrun), 32'(exp_ovr));
    @(negedge clk); clear_errors = 1'b1;
    @(negedge clk); clear_errors = 1'b0;
    exp_ovr = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'(exp_ovr));

    // Push and pop in the same cycle while full.
    for (int b = 8'h10; b <= 8'h13; b++) begin
      expect_frame(8'(b), 1'b1);
      drive_frame(8'(b), 1'b1);
    end
    chk("pp_full", 32'(fifo_full), 32'(exp_q.size() == DEPTH));
    frame_pop_at_push("full_pushpop", 8'h14);
    for (int i = 0; i < 4; i++) do_pop("pp_pop");

    // Reset in the middle of a frame, with a full FIFO and overrun set.
    for (int b = 0; b < 5; b++) begin
      expect_frame(8'(b * 37 + 11), 1'b1);
      drive_frame(8'(b * 37 + 11), 1'b1);
    end
    chk("pre_rst_ovr",  32'(overrun), 32'(exp_ovr));
    chk("pre_rst_head", 32'(PortIn), 32'(exp_q[0]));
    fork
      drive_frame(8'hF0, 1'b1);
      begin
        @(negedge clk);
        repeat (2 + BD / 2 + 5 * BD) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
      end
    join
    repeat (3) @(negedge clk);
    chk_reset_vals("rst_hold");
    reset = 1'b1;
    exp_q.delete();
    exp_ovr = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_release");
    mon_en = 1'b1;
    expect_frame(8'h99, 1'b1);
    drive_frame(8'h99, 1'b1);
    drain("after_rst");

    // Randomized frames, random stop bits and gaps (including back-to-back).
    for (int n = 0; n < 24; n++) begin
      rb  = 8'($urandom_range(0, 255));
      rs  = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, 2);
      expect_frame(rb, rs);
      drive_frame(rb, rs);
      repeat (gap * BD) @(negedge clk);
    end
    drain("random");
    chk("fe_count", 32'(fe_seen), 32'(fe_exp));
    chk("final_ovr", 32'(overrun), 32'(exp_ovr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
